bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The parameter N_REQ SHALL default to 4 and set the number of requesters (range 2..16).
REQ-002 The parameter ID_W SHALL default to $clog2(N_REQ) and set the width of gnt_id.
REQ-003 The parameter MAX_HOLD SHALL default to 16 and set the maximum number of cycles a grant may be held (range 1..255).
REQ-004 Port clk SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst_n SHALL be an input, 1 bit: synchronous, active-low reset.
REQ-006 Port req SHALL be an input, N_REQ bits: bit i high means requester i wants the shared resource.
REQ-007 Port done SHALL be an input, 1 bit: the current owner releases the resource this cycle.
REQ-008 Port gnt SHALL be an output, N_REQ bits: registered grant vector, one-hot or all-zero.
REQ-009 Port gnt_valid SHALL be an output, 1 bit: registered; equals |gnt.
REQ-010 Port gnt_id SHALL be an output, ID_W bits: registered index of the granted requester; 0 when gnt_valid is low.
REQ-011 Port timeout SHALL be an output, 1 bit: registered one-cycle pulse when a grant is revoked for exceeding MAX_HOLD.

Function
REQ-012 The FSM SHALL have exactly two states, IDLE (no owner) and BUSY (one owner).
REQ-013 The arbiter SHALL hold a priority pointer ptr (ID_W bits); arbitration SHALL select the first asserted req bit at index ptr, ptr+1, ..., N_REQ-1, 0, ..., ptr-1 (modulo N_REQ).
REQ-014 In IDLE, if req != 0 at an edge, gnt SHALL become one-hot at the selected index at that edge (1-cycle latency from req sample to grant), and the FSM SHALL go to BUSY.
REQ-015 In IDLE with req == 0, outputs SHALL stay zero and the FSM SHALL stay in IDLE.
REQ-016 In BUSY, gnt SHALL remain unchanged until release, regardless of other req bits.
REQ-017 Release SHALL occur on any of: done high; req[gnt_id] low; hold counter reaching MAX_HOLD.
REQ-018 On release, ptr SHALL become (gnt_id+1) mod N_REQ.
REQ-019 On release, if any req bit other than the releasing owner's is set, the next owner SHALL be granted at the same edge, with arbitration from the new ptr (back-to-back, no idle cycle), and the FSM SHALL stay in BUSY.
REQ-020 On release with no other req pending, gnt SHALL go to zero and the FSM SHALL go to IDLE.
REQ-021 The releasing owner SHALL NOT be re-granted at the release edge even if its req is still high.
REQ-022 A hold counter (8 bits) SHALL clear on every new grant and increment each BUSY cycle without release.
REQ-023 When the hold counter equals MAX_HOLD-1 and done is low, the grant SHALL be revoked at the next edge, timeout SHALL pulse high for exactly one cycle, and REQ-018..REQ-020 SHALL apply.
REQ-024 If done and the timeout condition coincide, done SHALL win and timeout SHALL stay low.
REQ-025 done asserted in IDLE SHALL be ignored.
REQ-026 gnt SHALL never have more than one bit set ($onehot0 at every cycle).
REQ-027 When N_REQ is not a power of two, ptr SHALL wrap from N_REQ-1 to 0 and never hold an out-of-range value.

Reset
REQ-028 While rst_n is low at a clock edge, the FSM SHALL go to IDLE; gnt, gnt_valid, gnt_id, timeout, ptr and the hold counter SHALL be 0.
REQ-029 Reset asserted during BUSY SHALL drop the grant at that edge with no timeout pulse; the first grant after reset SHALL arbitrate from ptr = 0.
REQ-030 Reset SHALL take effect only on a clock edge; there SHALL be no asynchronous path.

Verification
REQ-031 Scenario: after reset, req=4'b1010 -> next edge gnt=4'b0010, gnt_id=1; done pulse -> same edge gnt=4'b1000, gnt_id=3.
REQ-032 Scenario: req=4'b1111 held, done pulsed each cycle -> grants rotate 0,1,2,3,0 with no gap cycles.
REQ-033 Scenario: MAX_HOLD=4, req=4'b0001 held, done low -> gnt=4'b0001 for 4 cycles, then timeout=1 for one cycle, gnt=0, then re-grant to 0 the following cycle.
REQ-034 Scenario: owner 2 granted, req[2] drops with req[0] high -> same edge gnt=4'b0001, ptr=3 before that arbitration.
REQ-035 Scenario: rst_n low while BUSY with gnt=4'b0100 -> next edge all outputs 0; after release of reset, req=4'b0100 -> gnt=4'b0100.
REQ-036 Checker: gnt is $onehot0, gnt_valid equals |gnt, gnt_id matches gnt, and timeout is never high for two consecutive cycles; cover a grant to every index.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter with a registered one-hot grant, release on done/drop/hold-limit, and a timeout pulse.
module bus_arbiter #(
  parameter int N_REQ    = 4,
  parameter int ID_W     = $clog2(N_REQ),
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [ID_W-1:0]  gnt_id,
  output logic             timeout
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);
  state_t state;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] nxt_ptr;
  logic [7:0] hold;
  logic [N_REQ-1:0] others;
  logic expire;
  logic rel;
  function automatic logic [ID_W-1:0] pick(input logic [N_REQ-1:0] r, input logic [ID_W-1:0] p);
    logic [ID_W-1:0] s;
    logic f;
    int idx;
    s = '0;
    f = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(p) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!f && r[idx]) begin
        s = ID_W'(idx);
        f = 1'b1;
      end
    end
    return s;
  endfunction
  always_comb begin
    nxt_ptr = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
    others  = req & ~gnt;
    expire  = hold == 8'(MAX_HOLD - 1);
    rel     = done || !req[gnt_id] || expire;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      timeout   <= 1'b0;
      ptr       <= '0;
      hold      <= '0;
    end else begin
      timeout <= 1'b0;
      if (state == IDLE) begin
        if (|req) begin
          state     <= BUSY;
          gnt       <= ONE << pick(req, ptr);
          gnt_id    <= pick(req, ptr);
          gnt_valid <= 1'b1;
          hold      <= '0;
        end
      end else if (rel) begin
        ptr     <= nxt_ptr;
        timeout <= expire && !done;
        hold    <= '0;
        if (|others) begin
          gnt    <= ONE << pick(others, nxt_ptr);
          gnt_id <= pick(others, nxt_ptr);
        end else begin
          state     <= IDLE;
          gnt       <= '0;
          gnt_valid <= 1'b0;
          gnt_id    <= '0;
        end
      end else begin
        hold <= hold + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: scoreboard bench; a queue-fed monitor compares the arbiter against an owner/pointer reference model.
module tb_bus_arbiter;
  localparam int N = 4;
  localparam int MAXH = 4;
  typedef struct packed {
    logic [3:0] g;
    logic [1:0] id;
    logic       to;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req = '0;
  logic done = 1'b0;
  logic [3:0] gnt;
  logic gnt_valid;
  logic [1:0] gnt_id;
  logic timeout;
  exp_t sbq[$];
  int n_checks = 0;
  int n_fail = 0;
  int m_owner = -1;
  int m_ptr = 0;
  int m_cnt = 0;
  bit m_to = 1'b0;
  logic prev_to = 1'b0;
  logic [3:0] seen = '0;

  bus_arbiter #(.N_REQ(N), .MAX_HOLD(MAXH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt), .gnt_valid(gnt_valid), .gnt_id(gnt_id), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic int scan(input logic [3:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] r, input logic d, input logic rn);
    exp_t e;
    logic [3:0] r2;
    if (!rn) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner < 0) begin
        m_owner = scan(r, m_ptr);
        m_cnt = 0;
      end else if (d || !r[m_owner] || m_cnt == MAXH - 1) begin
        m_to = (m_cnt == MAXH - 1) && !d;
        m_ptr = (m_owner + 1) % N;
        r2 = r;
        r2[m_owner] = 1'b0;
        m_owner = scan(r2, m_ptr);
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    e.g  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
    e.id = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    e.to = m_to;
    sbq.push_back(e);
  endtask

  task automatic drive(input logic [3:0] r, input logic d, input logic rn);
    req = r; done = d; rst_n = rn;
    @(posedge clk);
    #1;
    model_step(r, d, rn);
  endtask

  task automatic expect_now(input string nm, input logic [3:0] eg, input logic et);
    chk({nm, "_gnt"}, 32'(gnt), 32'(eg));
    chk({nm, "_timeout"}, 32'(timeout), 32'(et));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("sb_gnt", 32'(gnt), 32'(e.g));
        chk("sb_gnt_id", 32'(gnt_id), 32'(e.id));
        chk("sb_timeout", 32'(timeout), 32'(e.to));
        chk("sb_gnt_valid", 32'(gnt_valid), 32'(|e.g));
        chk("inv_onehot0", 32'($onehot0(gnt)), 32'd1);
        chk("inv_valid_or", 32'(gnt_valid), 32'(|gnt));
        chk("inv_id_match", 32'(gnt_valid ? (gnt == 4'(1 << gnt_id)) : (gnt_id == 2'd0)), 32'd1);
        chk("inv_timeout_pulse", 32'(timeout && prev_to), 32'd0);
        prev_to = timeout;
        seen = seen | gnt;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    drive(4'b0000, 1'b0, 1'b0);
    drive(4'b0000, 1'b0, 1'b0);
    expect_now("reset", 4'b0000, 1'b0);
    chk("reset_id", 32'(gnt_id), 32'd0);
    drive(4'b1010, 1'b0, 1'b1);
    expect_now("s1_first", 4'b0010, 1'b0);
    chk("s1_first_id", 32'(gnt_id), 32'd1);
    drive(4'b1010, 1'b1, 1'b1);
    expect_now("s1_b2b", 4'b1000, 1'b0);
    chk("s1_b2b_id", 32'(gnt_id), 32'd3);
    drive(4'b0000, 1'b1, 1'b1);
    expect_now("s1_idle", 4'b0000, 1'b0);
    drive(4'b1111, 1'b0, 1'b1);
    expect_now("rot0", 4'b0001, 1'b0);
    drive(4'b1111, 1'b1, 1'b1);
    expect_now("rot1", 4'b0010, 1'b0);
    drive(4'b1111, 1'b1, 1'b1);
    expect_now("rot2", 4'b0100, 1'b0);
    drive(4'b1111, 1'b1, 1'b1);
    expect_now("rot3", 4'b1000, 1'b0);
    drive(4'b1111, 1'b1, 1'b1);
    expect_now("rot4", 4'b0001, 1'b0);
    drive(4'b0000, 1'b1, 1'b1);
    expect_now("rot_idle", 4'b0000, 1'b0);
    for (int i = 0; i < MAXH; i++) begin
      drive(4'b0001, 1'b0, 1'b1);
      expect_now("hold", 4'b0001, 1'b0);
    end
    drive(4'b0001, 1'b0, 1'b1);
    expect_now("timeout_hit", 4'b0000, 1'b1);
    drive(4'b0001, 1'b0, 1'b1);
    expect_now("timeout_regrant", 4'b0001, 1'b0);
    drive(4'b0000, 1'b0, 1'b1);
    expect_now("drop_idle", 4'b0000, 1'b0);
    drive(4'b0100, 1'b0, 1'b1);
    expect_now("own2", 4'b0100, 1'b0);
    drive(4'b0001, 1'b0, 1'b1);
    expect_now("drop_handoff", 4'b0001, 1'b0);
    drive(4'b0000, 1'b0, 1'b1);
    drive(4'b0100, 1'b0, 1'b1);
    expect_now("pre_reset", 4'b0100, 1'b0);
    drive(4'b0100, 1'b0, 1'b0);
    expect_now("busy_reset", 4'b0000, 1'b0);
    chk("busy_reset_valid", 32'(gnt_valid), 32'd0);
    drive(4'b0100, 1'b0, 1'b1);
    expect_now("post_reset", 4'b0100, 1'b0);
    for (int i = 0; i < MAXH - 1; i++) drive(4'b0100, 1'b0, 1'b1);
    drive(4'b0100, 1'b1, 1'b1);
    expect_now("done_beats_timeout", 4'b0000, 1'b0);
    for (int i = 0; i < 3000; i++)
      drive(4'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 99) != 0);
    drive(4'b0000, 1'b0, 1'b1);
    drive(4'b0000, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    chk("cover_all_grants", 32'(seen), 32'hF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
